// File: rtl/xor16_arb_pkg.sv
// Shared types and constants for the two-requester XOR arbiter.
// Build option: XOR16_ARB_RR_EN selects round-robin instead of fixed priority.
package xor16_arb_pkg;

    localparam int XOR16_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    typedef logic req_id_t;

    // Requester 0 wins the first contention after reset.
    localparam req_id_t LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/xor16_unit.sv
// Shared combinational XOR datapath; one instance serves both requesters.
module xor16_unit
    import xor16_arb_pkg::*;
#(
    parameter int W = XOR16_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor16_arbiter.sv
// Two-requester arbiter in front of one shared XOR unit, holding one tagged result at a time.
// Build option: define XOR16_ARB_RR_EN for round-robin; default is fixed priority to requester 0.
module xor16_arbiter
    import xor16_arb_pkg::*;
#(
    parameter int W = XOR16_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_ready,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_data,
    output logic         rsp_id,
    input  logic         rsp_ready,
    output logic [15:0]  op_count
);

    state_t       state;
    req_id_t      last_grant;
    req_id_t      grant_id;
    logic         idle;
    logic         accept;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] xor_y;

    always_comb begin
        // NOTE: assign a default before any branch so every path drives grant_id and no latch is inferred.
        grant_id = 1'b0;
`ifdef XOR16_ARB_RR_EN
        if (req0_valid && req1_valid)
            grant_id = ~last_grant;
        else
            grant_id = req1_valid;
`else
        grant_id = !req0_valid && req1_valid;
`endif
    end

`ifndef XOR16_ARB_RR_EN
    // Fixed priority still tracks the last grant; it simply never steers the decision.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    assign idle       = (state == IDLE);
    assign req0_ready = idle && req0_valid && (grant_id == 1'b0);
    assign req1_ready = idle && req1_valid && (grant_id == 1'b1);
    assign accept     = req0_ready || req1_ready;

    assign op_a = grant_id ? req1_a : req0_a;
    assign op_b = grant_id ? req1_b : req0_b;

    xor16_unit #(.W(W)) u_xor (
        .a (op_a),
        .b (op_b),
        .y (xor_y)
    );

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            last_grant <= LAST_GRANT_RST;
            op_count   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_data   <= xor_y;
                        rsp_id     <= grant_id;
                        rsp_valid  <= 1'b1;
                        last_grant <= grant_id;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    // Result stays frozen until the consumer takes it; no new request overlaps.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor16_arbiter.sv
// Randomized scoreboard bench for xor16_arbiter; expectations come from a behavioural grant/queue model.
// Honours XOR16_ARB_RR_EN the same way the design does.
module tb_xor16_arbiter;

    typedef struct packed {
        logic        id;
        logic [15:0] data;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_id;
    logic        rsp_ready;
    logic [15:0] op_count;

    int   errors = 0;
    int   checks = 0;
    int   exp_count = 0;
    rsp_t sb[$];

    // Model of the arbiter as seen from outside: busy while a result is outstanding.
    bit busy = 0;
    int last = 1;
    bit acc0 = 0, acc1 = 0;

    xor16_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input bit v0, input bit v1, input int prev);
        if (v0 && v1) begin
`ifdef XOR16_ARB_RR_EN
            return 1 - prev;
`else
            return 0;
`endif
        end
        return v0 ? 0 : 1;
    endfunction

    // One clock: check grant decisions at the falling edge, then return just after the rising edge.
    task automatic cycle();
        bit   e0, e1;
        int   g;
        rsp_t e;
        @(negedge clk);
        acc0 = 0;
        acc1 = 0;
        if (rst) begin
            busy = 0;
            last = 1;
            sb.delete();
        end else begin
            e0 = 0;
            e1 = 0;
            g  = 0;
            if (!busy && (req0_valid || req1_valid)) begin
                g  = pick(req0_valid, req1_valid, last);
                e0 = (g == 0);
                e1 = (g == 1);
            end
            check("req0_ready", {31'b0, req0_ready}, {31'b0, e0});
            check("req1_ready", {31'b0, req1_ready}, {31'b0, e1});
            check("rsp_valid", {31'b0, rsp_valid}, {31'b0, busy});
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            if (busy) begin
                if (rsp_ready) busy = 0;
            end else if (e0 || e1) begin
                e.id   = g[0];
                e.data = (g == 0) ? (req0_a ^ req0_b) : (req1_a ^ req1_b);
                sb.push_back(e);
                busy = 1;
                last = g;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Requesters hold valid and operands until accepted; p* are percent probabilities.
    task automatic drive(input int unsigned p0, input int unsigned p1, input int unsigned pr);
        if (!req0_valid || acc0) begin
            req0_valid = ($urandom_range(99) < p0);
            req0_a     = 16'($urandom);
            req0_b     = 16'($urandom);
        end
        if (!req1_valid || acc1) begin
            req1_valid = ($urandom_range(99) < p1);
            req1_a     = 16'($urandom);
            req1_b     = 16'($urandom);
        end
        rsp_ready = ($urandom_range(99) < pr);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || req0_valid || req1_valid) && n < 12) begin
            drive(0, 0, 100);
            cycle();
            n++;
        end
        if (busy || req0_valid || req1_valid) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: got busy=%0d after %0d cycles, expected idle", busy, n);
        end
    endtask

    // Monitor: compares every presented response with the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_count = 0;
            end else begin
                check("op_count", {16'b0, op_count}, exp_count);
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL rsp_unexpected: got id=%0d data=%h, expected no response", rsp_id, rsp_data);
                    end else begin
                        check("rsp_data", {16'b0, rsp_data}, {16'b0, sb[0].data});
                        check("rsp_id", {31'b0, rsp_id}, {31'b0, sb[0].id});
                        if (rsp_ready) begin
                            void'(sb.pop_front());
                            exp_count = (exp_count + 1) % 65536;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int start;
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a     = '0;
        req0_b     = '0;
        req1_a     = '0;
        req1_b     = '0;
        rsp_ready  = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rsp_data", {16'b0, rsp_data}, 32'd0);
        check("reset_rsp_id", {31'b0, rsp_id}, 32'd0);
        check("reset_op_count", {16'b0, op_count}, 32'd0);
        cycle();

        // Single request from requester 0.
        req0_valid = 1'b1;
        req0_a     = 16'hF0F0;
        req0_b     = 16'h0FF0;
        rsp_ready  = 1'b1;
        cycle();
        req0_valid = 1'b0;
        check("single_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("single_rsp_data", {16'b0, rsp_data}, 32'h0000FF00);
        check("single_rsp_id", {31'b0, rsp_id}, 32'd0);
        cycle();
        check("single_op_count", {16'b0, op_count}, 32'd1);
        drain();

        // Continuous contention with the consumer always ready: four operations in eight cycles.
        start = exp_count;
        repeat (8) begin
            drive(100, 100, 100);
            cycle();
        end
        check("contention_op_count", {16'b0, op_count}, start + 4);
        req0_valid = req0_valid && !acc0;
        req1_valid = req1_valid && !acc1;
        drain();

        // Backpressure: result held for five cycles, then one handshake.
        start = exp_count;
        drive(0, 100, 0);
        cycle();
        repeat (5) begin
            drive(0, 0, 0);
            cycle();
        end
        check("bp_held_count", {16'b0, op_count}, start);
        drive(0, 0, 100);
        cycle();
        check("bp_op_count", {16'b0, op_count}, start + 1);
        drain();

        // Reset while a result is pending.
        drive(100, 0, 0);
        cycle();
        drive(0, 0, 0);
        cycle();
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cycle();
        rst = 1'b0;
        check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("midrst_op_count", {16'b0, op_count}, 32'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        acc0 = 1;
        acc1 = 1;
        drive(100, 100, 100);
        cycle();
        check("midrst_first_grant", {31'b0, rsp_id}, 32'd0);
        repeat (3) begin
            drive(100, 100, 100);
            cycle();
        end
        req0_valid = req0_valid && !acc0;
        req1_valid = req1_valid && !acc1;
        drain();

        // Randomized traffic with random backpressure.
        repeat (400) begin
            drive(60, 60, 70);
            cycle();
        end
        drain();

        // Counter wrap: preload to all ones, then complete one operation.
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        exp_count = 65535;
        drive(100, 0, 100);
        cycle();
        drive(0, 0, 100);
        cycle();
        check("wrap_op_count", {16'b0, op_count}, 32'd0);
        drain();
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
